// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and helpers for the UART transmit path
// Purpose: state encodings, line levels and the parity helper used by uart_tx_frame.
// Ports: none (package).
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } txState_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Parity bit that makes the total count of ones (data + parity) even or odd.
    function automatic logic calcParity(input logic [DATA_BITS-1:0] data, input logic parityType);
        return (parityType == PARITY_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter for the UART transmitter
// Purpose: counts 0..CLKS_PER_BIT-1 while Run is high and flags the last clock of each bit.
// Ports:
//   Clock   in  system clock
//   Reset   in  synchronous active-high reset
//   Clear   in  restart the bit period (asserted on every accept)
//   Run     in  count enable; the counter is held at zero while low
//   BitEnd  out high during the final clock of the current bit
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    input  logic Run,
    output logic BitEnd
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clock) begin
        if (Reset || Clear || !Run) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign BitEnd = Run && (count == LAST_COUNT);

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit framer and serialiser
// Purpose: accepts a byte through a Ready/Send handshake and shifts out
//   start(0), 8 data bits LSB-first, optional parity, stop(1), each held CLKS_PER_BIT clocks.
// Configuration: define UART_TX_PARITY_EN to include the parity bit (11-bit frame);
//   otherwise the frame is 10 bits and ParityType is ignored.
// Ports:
//   Clock       in   system clock
//   Reset       in   synchronous active-high reset
//   Send        in   transmit request, honoured only while Ready=1
//   DataIn      in   byte to transmit
//   ParityType  in   0 = even, 1 = odd; latched with DataIn
//   Ready       out  idle, a byte can be accepted this cycle
//   TxOut       out  registered serial line, idles high
//   Done        out  one-cycle pulse after the last stop-bit clock
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_WIDTH   = DATA_BITS
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Send,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  ParityType,
    output logic                  Ready,
    output logic                  TxOut,
    output logic                  Done
);

    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    txState_t state, stateNext;
    logic [DATA_WIDTH-1:0] shiftReg, shiftNext;
    logic [IW-1:0] bitIdx, bitIdxNext;
    logic txReg, txNext;
    logic doneReg, doneNext;
    logic accept;
    logic bitEnd;

`ifdef UART_TX_PARITY_EN
    logic parityReg, parityNext;
`else
    logic unusedParityType;
    assign unusedParityType = ParityType;
`endif

    assign accept = (state == IDLE) && Send;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) baudTick (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (accept),
        .Run   (state != IDLE),
        .BitEnd(bitEnd)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            shiftReg <= '0;
            bitIdx   <= '0;
            txReg    <= IDLE_LEVEL;
            doneReg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parityReg <= 1'b0;
`endif
        end else begin
            state    <= stateNext;
            shiftReg <= shiftNext;
            bitIdx   <= bitIdxNext;
            txReg    <= txNext;
            doneReg  <= doneNext;
`ifdef UART_TX_PARITY_EN
            parityReg <= parityNext;
`endif
        end
    end

    // The next line level is decided one bit ahead so TxOut changes on the same
    // edge as the state, keeping each level exactly CLKS_PER_BIT clocks long.
    always_comb begin
        stateNext  = state;
        shiftNext  = shiftReg;
        bitIdxNext = bitIdx;
        txNext     = txReg;
        doneNext   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parityNext = parityReg;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    shiftNext  = DataIn;
                    bitIdxNext = '0;
                    txNext     = START_BIT;
                    stateNext  = START;
`ifdef UART_TX_PARITY_EN
                    parityNext = calcParity(DataIn, ParityType);
`endif
                end
            end
            START: begin
                if (bitEnd) begin
                    txNext    = shiftReg[0];
                    shiftNext = shiftReg >> 1;
                    stateNext = DATA;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    if (bitIdx == LAST_IDX) begin
                        bitIdxNext = '0;
`ifdef UART_TX_PARITY_EN
                        txNext    = parityReg;
                        stateNext = PARITY;
`else
                        txNext    = STOP_BIT;
                        stateNext = STOP;
`endif
                    end else begin
                        txNext     = shiftReg[0];
                        shiftNext  = shiftReg >> 1;
                        bitIdxNext = bitIdx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bitEnd) begin
                    txNext    = STOP_BIT;
                    stateNext = STOP;
                end
            end
            STOP: begin
                if (bitEnd) begin
                    txNext    = IDLE_LEVEL;
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: begin
                txNext    = IDLE_LEVEL;
                stateNext = IDLE;
            end
        endcase
    end

    assign Ready = (state == IDLE);
    assign TxOut = txReg;
    assign Done  = doneReg;

endmodule
